// File: rtl/acc_pkg.sv
// acc_pkg: opcode constants, FSM state encoding and decode helper for acc_seq
package acc_pkg;
   localparam logic [2:0] OP_TC   = 3'd0;
   localparam logic [2:0] OP_CA   = 3'd3;
   localparam logic [2:0] OP_CS   = 3'd4;
   localparam logic [2:0] OP_TS   = 3'd5;
   localparam logic [2:0] OP_AD   = 3'd6;
   localparam logic [2:0] OP_MASK = 3'd7;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_READ_OP = 3'd2;
   localparam logic [2:0] ST_EXEC0   = 3'd3;
   localparam logic [2:0] ST_EXEC1   = 3'd4;
   function automatic logic reads_operand(input logic [2:0] op);
      return op == OP_CA || op == OP_CS || op == OP_AD || op == OP_MASK;
   endfunction
endpackage

// File: rtl/acc_alu.sv
// acc_alu: combinational accumulator result for CA/CS/AD/MASK
module acc_alu
   import acc_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] d,
   input  logic [2:0]    op,
   output logic [DW-1:0] y
);
   logic [DW:0] sum;
   // one's-complement add folds the carry-out back into the LSB
   always_comb begin
      sum = {1'b0, a} + {1'b0, d};
      y = op == OP_CA   ? d :
          op == OP_CS   ? ~d :
          op == OP_MASK ? (a & d) :
          op == OP_AD   ? sum[DW-1:0] + {{(DW-1){1'b0}}, sum[DW]} : a;
   end
endmodule

// File: rtl/acc_seq.sv
// acc_seq: single-accumulator instruction sequencer driving an external memory
module acc_seq
   import acc_pkg::*;
#(
   parameter int            AW        = 12,
   parameter int            DW        = 16,
   parameter logic [AW-1:0] BOOT_ADDR = 12'h800
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          run,
   input  logic          step,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] acc,
   output logic [DW-2:0] g,
   output logic [AW-1:0] s,
   output logic          busy,
   output logic          instr_done,
   output logic          halted
);
   logic [2:0]    state, nxt;
   logic [2:0]    op;
   logic [AW-1:0] dir;
   logic [DW-1:0] alu_y;
   logic          go_on, halt_tc, rd_op;
   acc_alu #(.DW(DW)) u_alu (.a(acc), .d(mem_rdata), .op(op), .y(alu_y));
   // decode, next state and memory strobes; strobes are pure state decode so reset clears them at once
   always_comb begin
      op = g[AW+2:AW];
      dir = g[AW-1:0];
      rd_op = reads_operand(op);
      go_on = run & ~halted;
      halt_tc = state == ST_EXEC0 && op == OP_TC && dir == s - 1'b1;
      nxt = state == ST_IDLE              ? ((go_on | step) ? ST_FETCH : ST_IDLE) :
            state == ST_FETCH             ? ST_READ_OP :
            state == ST_READ_OP           ? ST_EXEC0 :
            state == ST_EXEC0 && rd_op    ? ST_EXEC1 :
            halt_tc                       ? ST_IDLE :
            go_on                         ? ST_FETCH : ST_IDLE;
      mem_rd = state == ST_FETCH || (state == ST_EXEC0 && rd_op);
      mem_we = state == ST_EXEC0 && op == OP_TS;
      mem_addr = state == ST_EXEC0 ? dir : s;
      mem_wdata = acc;
      instr_done = (state == ST_EXEC0 && !rd_op) || state == ST_EXEC1;
      busy = state != ST_IDLE;
   end
   // architectural registers; halted clears only on a step accepted in IDLE
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
         s <= BOOT_ADDR;
         g <= '0;
         acc <= '0;
         halted <= 1'b0;
      end else begin
         state <= nxt;
         if (state == ST_IDLE && step) halted <= 1'b0;
         if (state == ST_READ_OP) begin
            g <= mem_rdata[DW-2:0];
            s <= s + 1'b1;
         end
         if (state == ST_EXEC0 && op == OP_TC) s <= dir;
         if (halt_tc) halted <= 1'b1;
         if (state == ST_EXEC1) acc <= alu_y;
      end
   end
endmodule

// File: tb/tb_acc_seq.sv
// tb_acc_seq: directed self-checking bench for acc_seq with a behavioural memory
module tb_acc_seq;
   localparam int AW = 12;
   localparam int DW = 16;
   logic clk = 1'b0, rstn = 1'b0, run = 1'b0, step = 1'b0, load = 1'b0;
   logic [AW-1:0] mem_addr, s;
   logic mem_rd, mem_we, busy, instr_done, halted;
   logic [DW-1:0] mem_rdata, mem_wdata, acc;
   logic [DW-2:0] g;
   logic [DW-1:0] mem [0:4095];
   logic [DW-1:0] img [0:4095];
   int we_cnt = 0, done_cnt = 0, n_chk = 0, n_pass = 0;

   acc_seq #(.AW(AW), .DW(DW), .BOOT_ADDR(12'h800)) dut (
      .clk(clk), .rstn(rstn), .run(run), .step(step),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .acc(acc), .g(g), .s(s),
      .busy(busy), .instr_done(instr_done), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load) mem <= img;
      else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         we_cnt <= we_cnt + 1;
      end
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   always @(negedge clk) if (instr_done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic exec(input string tag, input int exp_cyc, input bit extra);
      int cyc = 0;
      int d0 = done_cnt;
      step = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         step = extra && i == 2;
         if (instr_done) begin
            cyc = i;
            break;
         end
      end
      step = 1'b0;
      check({tag, " cycles"}, cyc, exp_cyc);
      @(negedge clk);
      check({tag, " done count"}, done_cnt - d0, 1);
      check({tag, " idle after"}, busy, 0);
   endtask

   initial begin
      int w0, d0, bc, hit;
      for (int i = 0; i < 4096; i++) img[i] = '0;
      img['h800] = 16'h3900; img['h900] = 16'h1234;
      img['h801] = 16'h3902; img['h902] = 16'h0005;
      img['h802] = 16'h6903; img['h903] = 16'hFFFA;
      img['h803] = 16'h6905; img['h905] = 16'h0001;
      img['h804] = 16'h4906; img['h906] = 16'h00F0;
      img['h805] = 16'h7907; img['h907] = 16'h0FF0;
      img['h806] = 16'h1000; img['h807] = 16'h2ABC;
      img['h808] = 16'h5A00; img['h809] = 16'h0FFF;
      img['hFFF] = 16'h1000; img['h000] = 16'h5B00;
      load = 1'b1;
      repeat (2) @(negedge clk);
      load = 1'b0;
      check("rst busy", busy, 0);
      check("rst s", s, 12'h800);
      check("rst acc", acc, 0);
      check("rst g", g, 0);
      check("rst halted", halted, 0);
      check("rst mem_rd", mem_rd, 0);
      check("rst mem_we", mem_we, 0);
      check("rst mem_addr", mem_addr, 12'h800);
      check("rst mem_wdata", mem_wdata, 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check("idle without step", busy, 0);
      exec("CA 900", 4, 0);
      check("CA acc", acc, 16'h1234);
      check("CA s", s, 12'h801);
      check("CA g", g, 15'h3900);
      exec("CA 902", 4, 0);
      check("CA5 acc", acc, 16'h0005);
      exec("AD FFFA", 4, 0);
      check("AD no carry", acc, 16'hFFFF);
      exec("AD 0001", 4, 0);
      check("AD end-around", acc, 16'h0001);
      exec("CS", 4, 0);
      check("CS acc", acc, 16'hFF0F);
      exec("MASK", 4, 0);
      check("MASK acc", acc, 16'h0F00);
      exec("NOP1", 3, 1);
      check("NOP1 acc", acc, 16'h0F00);
      exec("NOP2", 3, 1);
      check("NOP2 acc", acc, 16'h0F00);
      check("NOP2 s", s, 12'h808);
      w0 = we_cnt;
      exec("TS", 3, 0);
      check("TS data", mem['hA00], 16'h0F00);
      check("TS one write", we_cnt - w0, 1);
      exec("TC", 3, 0);
      check("TC s", s, 12'hFFF);
      check("TC no halt", halted, 0);
      exec("NOP wrap", 3, 0);
      check("wrap s", s, 12'h000);
      w0 = we_cnt;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (2) @(negedge clk);
      check("TS exec0 we", mem_we, 1);
      rstn = 1'b0;
      #1;
      check("abort mem_we", mem_we, 0);
      check("abort busy", busy, 0);
      check("abort s", s, 12'h800);
      check("abort acc", acc, 0);
      check("abort g", g, 0);
      check("abort mem_rd", mem_rd, 0);
      check("abort mem_addr", mem_addr, 12'h800);
      check("abort done", instr_done, 0);
      repeat (2) @(negedge clk);
      check("abort no write", we_cnt - w0, 0);
      img['h801] = 16'h5901; img['h802] = 16'h0802; img['h901] = 16'h0000;
      load = 1'b1;
      repeat (2) @(negedge clk);
      load = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      w0 = we_cnt;
      run = 1'b1;
      hit = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (halted) begin
            hit = 1;
            break;
         end
      end
      check("halt reached", hit, 1);
      check("prog copy", mem['h901], 16'h1234);
      check("prog one write", we_cnt - w0, 1);
      check("halt idle", busy, 0);
      check("halt s", s, 12'h802);
      bc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bc += int'(busy);
      end
      check("run ignored while halted", bc, 0);
      d0 = done_cnt;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      check("step clears halt", halted, 0);
      check("step restarts", busy, 1);
      hit = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (halted) begin
            hit = 1;
            break;
         end
      end
      check("rehalt reached", hit, 1);
      check("rehalt one instr", done_cnt - d0, 1);
      check("rehalt s", s, 12'h802);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/acc_seq.md
ACC_SEQ -- requirements
Module: acc_seq

Interface
REQ-001 Parameter AW, default 12, memory address width in words.
REQ-002 Parameter DW, default 16, memory word width; SHALL satisfy DW >= AW+4.
REQ-003 Parameter BOOT_ADDR, default 12'h800, value of S after reset.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 run  input  1  1 = free-running execution, 0 = single-step.
REQ-007 step  input  1  one-cycle start pulse (debounced externally).
REQ-008 mem_addr  output  AW  word address to memory.
REQ-009 mem_rd  output  1  read strobe; data on mem_rdata the following cycle.
REQ-010 mem_rdata  input  DW  read data.
REQ-011 mem_we  output  1  write strobe, one cycle, with mem_addr/mem_wdata.
REQ-012 mem_wdata  output  DW  write data.
REQ-013 acc  output  DW  accumulator A.
REQ-014 g  output  DW-1  instruction register G.
REQ-015 s  output  AW  program address register S.
REQ-016 busy / instr_done / halted  output  1 each  not IDLE / last cycle of an instruction / halt latched.

Function
REQ-017 Fields: opcode = G[AW+2:AW]; dir = G[AW-1:0].
REQ-018 Opcodes: TC=0 jump, CA=3 load A, CS=4 load ~word, TS=5 store A, AD=6 add, MASK=7 AND; 1 and 2 SHALL execute as NOP.
REQ-019 States IDLE, FETCH, READ_OP, EXEC0, EXEC1.
REQ-020 IDLE: mem_rd=mem_we=0; to FETCH when (run & ~halted) | step.
REQ-021 FETCH: mem_rd=1, mem_addr=S; to READ_OP.
REQ-022 READ_OP: G <= mem_rdata[DW-2:0]; S <= S+1 modulo 2^AW (2^AW-1 wraps to 0); to EXEC0.
REQ-023 EXEC0, TC: S <= dir; instruction ends.
REQ-024 EXEC0, TS: mem_we=1, mem_addr=dir, mem_wdata=A; instruction ends.
REQ-025 EXEC0, CA/CS/AD/MASK: mem_rd=1, mem_addr=dir; to EXEC1.
REQ-026 EXEC0, NOP: instruction ends.
REQ-027 EXEC1: CA A<=rdata; CS A<=~rdata; MASK A<=A&rdata; AD A<=one's-complement sum; instruction ends.
REQ-028 AD: form DW+1-bit sum A+rdata, add carry-out back into LSB (end-around carry), truncate to DW bits.
REQ-029 Latency: TC/TS/NOP 3 cycles FETCH-to-end, others 4 cycles; instr_done high exactly in the ending cycle.
REQ-030 Instruction end: next state FETCH if run=1 and not halted, else IDLE.
REQ-031 Halt: TC with dir equal to its own address (S-1 before update) SHALL set halted and go to IDLE regardless of run.
REQ-032 halted SHALL clear, and execution restart, only on step in IDLE; run is ignored while halted.
REQ-033 step outside IDLE SHALL be ignored; step and run together in IDLE start one fetch only.
REQ-034 Mode change of run mid-instruction takes effect at instruction end.
REQ-035 busy = (state != IDLE).

Reset
REQ-036 rstn low SHALL immediately force state IDLE, S=BOOT_ADDR, G=0, A=0, halted=0, mem_rd=mem_we=instr_done=0, mem_addr=BOOT_ADDR, mem_wdata=0.
REQ-037 Reset mid-instruction SHALL abort it with no memory write after rstn falls.

Structure
REQ-038 Package acc_pkg SHALL hold opcode constants and the state encoding.
REQ-039 Sub-module acc_alu (combinational: CA/CS/AD/MASK result from A, rdata, opcode) SHALL hold all arithmetic.
REQ-040 Memory is external; acc_seq contains no storage array.

Verification
REQ-041 Reset, run=0, pulse step; mem[800]=3900 (CA 900), mem[900]=1234 -> acc=1234 after 4 cycles, S=801, instr_done once.
REQ-042 A=0005, AD word FFFA -> acc=FFFF; A=FFFF, AD 0001 -> acc=0001 (end-around carry).
REQ-043 run=1, program CA 900, TS 901, TC 802 (at 802) -> mem[901]=mem[900] written once, halted=1, state IDLE, S=802; further run ignored until step.
REQ-044 S=FFF executing NOP -> S wraps to 000.
REQ-045 rstn low during EXEC0 of TS -> no mem_we pulse, all outputs at reset values, S=800.
REQ-046 step pulses while busy -> no extra instruction executed; NOP opcodes 1/2 complete in 3 cycles with A unchanged.
